// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the text/font overlay.
// Divides clk into a pixel enable (p_tick), runs horizontal/vertical
// pixel counters and produces registered hsync/vsync that line up with
// pixel_x/pixel_y on the same cycle. Default timing is 640x480 @ 60 Hz.
//
// Optional build macro: VGA_FRAME_CNT_EN
//   defined   -> frame_tick pulses on the last pixel tick of a frame and
//                frame_cnt counts frames (8-bit, wrapping).
//   undefined -> frame_tick and frame_cnt are tied to zero.
// The port list is the same in both builds.
module vga_sync_gen #(
    parameter int DIV      = 2,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide, so the raster must fit in 1024x1024.
    if (H_TOT > 1024) begin : g_h_tot_chk
        $error("vga_sync_gen: H_TOT exceeds 1024");
    end
    if (V_TOT > 1024) begin : g_v_tot_chk
        $error("vga_sync_gen: V_TOT exceeds 1024");
    end
    if (DIV < 1) begin : g_div_chk
        $error("vga_sync_gen: DIV must be >= 1");
    end

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0]       H_DISP_C  = 10'(H_DISP);
    localparam logic [9:0]       V_DISP_C  = 10'(V_DISP);
    localparam logic [9:0]       HS_START  = 10'(H_DISP + H_FP);
    localparam logic [9:0]       HS_END    = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_START  = 10'(V_DISP + V_FP);
    localparam logic [9:0]       VS_END    = 10'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON   = 1'(SYNC_POL);

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Drive the asserted or idle sync level.
    function automatic logic sync_level(input logic active);
        return active ? SYNC_ON : ~SYNC_ON;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             h_end;
    logic             v_end;

    assign p_tick   = (div_cnt == DIV_LAST) && !reset;
    assign h_end    = (pixel_x == H_LAST);
    assign v_end    = (pixel_y == V_LAST);
    assign video_on = (pixel_x < H_DISP_C) && (pixel_y < V_DISP_C);

    // Clock divider: counts 0..DIV-1 and wraps, producing one p_tick per period.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next raster position; the vertical counter steps on the line wrap tick.
    always_comb begin
        h_nxt = pixel_x;
        v_nxt = pixel_y;
        if (p_tick) begin
            if (h_end) begin
                h_nxt = '0;
                v_nxt = v_end ? 10'd0 : pixel_y + 10'd1;
            end else begin
                h_nxt = pixel_x + 10'd1;
            end
        end
    end

    // Position and sync registers; syncs decode the next position so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x <= '0;
            pixel_y <= '0;
            hsync   <= ~SYNC_ON;
            vsync   <= ~SYNC_ON;
        end else begin
            pixel_x <= h_nxt;
            pixel_y <= v_nxt;
            hsync   <= sync_level(in_window(h_nxt, HS_START, HS_END));
            vsync   <= sync_level(in_window(v_nxt, VS_START, VS_END));
        end
    end

`ifdef VGA_FRAME_CNT_EN
    assign frame_tick = p_tick && h_end && v_end;

    // Frame counter for overlay blink timing; steps on the frame wrap tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_tick = 1'b0;
    assign frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances with reduced raster sizes share
// clk/reset: A (DIV=2, active-low syncs) and B (DIV=1, active-high syncs,
// very small frame so 257 frames fit in a short run). Expected outputs
// come from a closed-form model of elapsed clocks since reset.
module tb_vga_sync_gen;

    localparam int A_DIV = 2;
    localparam int A_HD = 8, A_HF = 2, A_HS = 3, A_HB = 3;
    localparam int A_VD = 6, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam bit A_POL = 1'b0;

    localparam int B_DIV = 1;
    localparam int B_HD = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VD = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam bit B_POL = 1'b1;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic [7:0] frame_cnt_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;
    logic [7:0] frame_cnt_b;

    vga_sync_gen #(
        .DIV(A_DIV), .H_DISP(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_DISP(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_POL(0)
    ) dut_a (
        .clk(clk), .reset(reset), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .video_on(video_on_a),
        .hsync(hsync_a), .vsync(vsync_a),
        .frame_tick(frame_tick_a), .frame_cnt(frame_cnt_a)
    );

    vga_sync_gen #(
        .DIV(B_DIV), .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(1)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(p_tick_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .video_on(video_on_b),
        .hsync(hsync_b), .vsync(vsync_b),
        .frame_tick(frame_tick_b), .frame_cnt(frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit pt;
        bit von;
        bit hs;
        bit vs;
        bit ft;
        int fc;
    } exp_t;

    typedef struct {
        bit rst;
        int cycles;
        int x;
        int y;
        bit von;
        bit hs;
        bit vs;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs after an edge, from reset state or k clean edges since reset.
    function automatic exp_t model(input bit r, input int kk, input int div,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input bit pol);
        exp_t e;
        int ht, vt, ftot, ticks, pos;
        ht   = hd + hf + hsw + hb;
        vt   = vd + vf + vsw + vb;
        ftot = ht * vt;
        if (r) begin
            e.x = 0; e.y = 0; e.pt = 0; e.von = 1;
            e.hs = !pol; e.vs = !pol; e.ft = 0; e.fc = 0;
        end else begin
            ticks = kk / div;
            pos   = ticks % ftot;
            e.x   = pos % ht;
            e.y   = pos / ht;
            e.pt  = ((kk % div) == div - 1);
            e.von = (e.x < hd) && (e.y < vd);
            e.hs  = (e.x >= hd + hf && e.x <= hd + hf + hsw - 1) ? pol : !pol;
            e.vs  = (e.y >= vd + vf && e.y <= vd + vf + vsw - 1) ? pol : !pol;
            e.ft  = FC_EN && e.pt && (pos == ftot - 1);
            e.fc  = FC_EN ? ((ticks / ftot) % 256) : 0;
        end
        return e;
    endfunction

    // One clock: drive reset, queue the expectation, compare at the falling edge.
    task automatic step(input bit r);
        exp_t ea, eb;
        reset = r;
        if (r) k = 0;
        else   k = k + 1;
        qa.push_back(model(r, k, A_DIV, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_POL));
        qb.push_back(model(r, k, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_POL));
        @(posedge clk);
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("A.pixel_x", 32'(pixel_x_a), ea.x);
        chk("A.pixel_y", 32'(pixel_y_a), ea.y);
        chk("A.p_tick", 32'(p_tick_a), 32'(ea.pt));
        chk("A.video_on", 32'(video_on_a), 32'(ea.von));
        chk("A.hsync", 32'(hsync_a), 32'(ea.hs));
        chk("A.vsync", 32'(vsync_a), 32'(ea.vs));
        chk("A.frame_tick", 32'(frame_tick_a), 32'(ea.ft));
        chk("A.frame_cnt", 32'(frame_cnt_a), ea.fc);
        chk("B.pixel_x", 32'(pixel_x_b), eb.x);
        chk("B.pixel_y", 32'(pixel_y_b), eb.y);
        chk("B.p_tick", 32'(p_tick_b), 32'(eb.pt));
        chk("B.video_on", 32'(video_on_b), 32'(eb.von));
        chk("B.hsync", 32'(hsync_b), 32'(eb.hs));
        chk("B.vsync", 32'(vsync_b), 32'(eb.vs));
        chk("B.frame_tick", 32'(frame_tick_b), 32'(eb.ft));
        chk("B.frame_cnt", 32'(frame_cnt_b), eb.fc);
    endtask

    vec_t vecs[10];

    initial begin
        int hs_a_cnt, hs_b_cnt, vs_a_cnt, vs_b_cnt, ft_a_cnt, ft_b_cnt;
        reset = 1'b1;

        // Phase table: reset value, clocks to run, end-state position/levels for instance A.
        vecs[0] = '{1'b1,     3,  0, 0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b0,     6,  3, 0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0,    26,  0, 1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0,   287, 15, 9, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0,     1,  0, 0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0,   168,  4, 5, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1,     1,  0, 0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0,     5,  2, 0, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0,   221,  1, 7, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 12114, 10, 5, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].rst);
            chk($sformatf("vec%0d.pixel_x", i), 32'(pixel_x_a), vecs[i].x);
            chk($sformatf("vec%0d.pixel_y", i), 32'(pixel_y_a), vecs[i].y);
            chk($sformatf("vec%0d.video_on", i), 32'(video_on_a), 32'(vecs[i].von));
            chk($sformatf("vec%0d.hsync", i), 32'(hsync_a), 32'(vecs[i].hs));
            chk($sformatf("vec%0d.vsync", i), 32'(vsync_a), 32'(vecs[i].vs));
        end

        // One full line of A (32 clks) and four lines of B: hsync width in clocks.
        hs_a_cnt = 0;
        hs_b_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            step(1'b0);
            if (hsync_a == 1'b0) hs_a_cnt++;
            if (hsync_b == 1'b1) hs_b_cnt++;
        end
        chk("A.hsync_width", hs_a_cnt, A_HS * A_DIV);
        chk("B.hsync_width", hs_b_cnt, 4 * B_HS * B_DIV);

        // 960 clks = 3 frames of A and 20 frames of B: vsync length and frame pulses.
        vs_a_cnt = 0; vs_b_cnt = 0; ft_a_cnt = 0; ft_b_cnt = 0;
        for (int c = 0; c < 960; c++) begin
            step(1'b0);
            if (vsync_a == 1'b0) vs_a_cnt++;
            if (vsync_b == 1'b1) vs_b_cnt++;
            if (frame_tick_a) ft_a_cnt++;
            if (frame_tick_b) ft_b_cnt++;
        end
        chk("A.vsync_len", vs_a_cnt, 3 * A_VS * 16 * A_DIV);
        chk("B.vsync_len", vs_b_cnt, 20 * B_VS * 8 * B_DIV);
        chk("A.frame_pulses", ft_a_cnt, FC_EN ? 3 : 0);
        chk("B.frame_pulses", ft_b_cnt, FC_EN ? 20 : 0);

        // Reset on a cycle where B would tick: reset wins, then counting restarts.
        step(1'b1);
        chk("B.reset_prio_x", 32'(pixel_x_b), 0);
        chk("B.reset_prio_tick", 32'(p_tick_b), 0);
        step(1'b0);
        step(1'b0);
        chk("A.restart_x", 32'(pixel_x_a), 1);
        chk("B.restart_x", 32'(pixel_x_b), 2);

        chk("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
